// File: rtl/led_fader.sv
// led_fader: two-channel (red/green) LED brightness fader with PWM dimming.
//
// Each channel ramps its current brightness (cur) toward a target that is
// either the channel's MAX register or zero, depending on the on/off request.
// Ramp steps are applied once per fade tick (every TICK_DIV xclk cycles), by
// STEP counts, clamped so the target is never overshot. STEP=0 jumps straight
// to the target. A shared PWM counter turns cur into a dimmed LED drive.
//
// Ports:
//   xclk       system clock, all state updates on the rising edge
//   sys_rst    asynchronous active-high reset (deassertion synchronised)
//   red_in     red on/off request
//   green_in   green on/off request
//   wr_stb     single-cycle register write strobe
//   wr_addr    write address: 0 MAX_R, 1 MAX_G, 2 STEP, 3 STATUS (read-only)
//   wr_data    write data
//   rd_addr    read address (same map)
//   rd_data    registered read data, one cycle after rd_addr is sampled
//   led_r      PWM-dimmed red drive (registered)
//   led_g      PWM-dimmed green drive (registered)
//   fade_busy  registered OR of both channels' ramp-busy flags
module led_fader #(
  parameter int TICK_DIV = 256,
  parameter int PWM_W    = 8
) (
  input  logic             xclk,
  input  logic             sys_rst,
  input  logic             red_in,
  input  logic             green_in,
  input  logic             wr_stb,
  input  logic [1:0]       wr_addr,
  input  logic [PWM_W-1:0] wr_data,
  input  logic [1:0]       rd_addr,
  output logic [PWM_W-1:0] rd_data,
  output logic             led_r,
  output logic             led_g,
  output logic             fade_busy
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [PWM_W-1:0] PWM_FULL  = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] PWM_LAST  = PWM_FULL - PWM_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  // Saturating ramp arithmetic. The upward sum is one bit wider so it can
  // never wrap; the downward path compares the remaining gap with STEP so
  // it can never underflow.
  function automatic logic [PWM_W-1:0] sat_up(input logic [PWM_W-1:0] cur,
                                              input logic [PWM_W-1:0] step,
                                              input logic [PWM_W-1:0] tgt);
    logic [PWM_W:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (sum >= {1'b0, tgt}) sat_up = tgt;
    else                    sat_up = sum[PWM_W-1:0];
  endfunction

  function automatic logic [PWM_W-1:0] sat_dn(input logic [PWM_W-1:0] cur,
                                              input logic [PWM_W-1:0] step,
                                              input logic [PWM_W-1:0] tgt);
    logic [PWM_W-1:0] gap;
    gap = cur - tgt;
    if (gap <= step) sat_dn = tgt;
    else             sat_dn = cur - step;
  endfunction

  // Reset synchroniser: assertion is immediate, release waits two edges.
  logic rst_meta_q;
  logic rst_q;

  always_ff @(posedge xclk or posedge sys_rst) begin
    if (sys_rst) begin
      rst_meta_q <= 1'b1;
      rst_q      <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_q      <= rst_meta_q;
    end
  end

  logic [PWM_W-1:0] max_r_q, max_g_q, step_q;
  logic [PRE_W-1:0] presc_q;
  logic [PWM_W-1:0] pwm_cnt_q;
  logic [PWM_W-1:0] cur_r_q, cur_r_d, cur_g_q, cur_g_d;
  state_t           st_r_q, st_r_d, st_g_q, st_g_d;
  logic             led_r_q, led_g_q, fade_busy_q;
  logic [PWM_W-1:0] rd_data_q, rd_data_d;

  logic             tick;
  logic [PWM_W-1:0] tgt_r, tgt_g;
  logic             busy_r, busy_g;
  logic [PWM_W-1:0] status;

  // Register file. STATUS is derived, so writes to address 3 fall through.
  always_ff @(posedge xclk or posedge rst_q) begin
    if (rst_q) begin
      max_r_q <= PWM_FULL;
      max_g_q <= PWM_FULL;
      step_q  <= PWM_W'(1);
    end else if (wr_stb) begin
      case (wr_addr)
        2'd0:    max_r_q <= wr_data;
        2'd1:    max_g_q <= wr_data;
        2'd2:    step_q  <= wr_data;
        default: ;
      endcase
    end
  end

  assign tick = (presc_q == PRE_LAST);

  // Targets follow the requests combinationally, so a request change and a
  // tick in the same cycle ramp toward the new target. MAX changes only
  // reach the target after the register has been written.
  assign tgt_r = red_in   ? max_r_q : '0;
  assign tgt_g = green_in ? max_g_q : '0;

  // Per-channel FSM: the state is chosen fresh every cycle from cur vs
  // target, and the ramp step is applied in the direction of that state.
  always_comb begin
    st_r_d  = IDLE;
    cur_r_d = cur_r_q;
    if (cur_r_q < tgt_r)      st_r_d = UP;
    else if (cur_r_q > tgt_r) st_r_d = DOWN;
    if (step_q == '0) begin
      cur_r_d = tgt_r;
    end else if (tick) begin
      case (st_r_d)
        UP:      cur_r_d = sat_up(cur_r_q, step_q, tgt_r);
        DOWN:    cur_r_d = sat_dn(cur_r_q, step_q, tgt_r);
        default: cur_r_d = cur_r_q;
      endcase
    end
  end

  always_comb begin
    st_g_d  = IDLE;
    cur_g_d = cur_g_q;
    if (cur_g_q < tgt_g)      st_g_d = UP;
    else if (cur_g_q > tgt_g) st_g_d = DOWN;
    if (step_q == '0) begin
      cur_g_d = tgt_g;
    end else if (tick) begin
      case (st_g_d)
        UP:      cur_g_d = sat_up(cur_g_q, step_q, tgt_g);
        DOWN:    cur_g_d = sat_dn(cur_g_q, step_q, tgt_g);
        default: cur_g_d = cur_g_q;
      endcase
    end
  end

  assign busy_r = (st_r_q != IDLE);
  assign busy_g = (st_g_q != IDLE);

  always_comb begin
    status      = '0;
    status[3:0] = {cur_r_q != '0, cur_g_q != '0, busy_r, busy_g};
  end

  always_comb begin
    case (rd_addr)
      2'd0:    rd_data_d = max_r_q;
      2'd1:    rd_data_d = max_g_q;
      2'd2:    rd_data_d = step_q;
      default: rd_data_d = status;
    endcase
  end

  // The PWM period is 2^PWM_W-1 counts so that full scale (all ones) is a
  // solid 1 and zero is a solid 0.
  always_ff @(posedge xclk or posedge rst_q) begin
    if (rst_q) begin
      presc_q     <= '0;
      pwm_cnt_q   <= '0;
      cur_r_q     <= '0;
      cur_g_q     <= '0;
      st_r_q      <= IDLE;
      st_g_q      <= IDLE;
      led_r_q     <= 1'b0;
      led_g_q     <= 1'b0;
      fade_busy_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      presc_q     <= tick ? '0 : presc_q + PRE_W'(1);
      pwm_cnt_q   <= (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_W'(1);
      cur_r_q     <= cur_r_d;
      cur_g_q     <= cur_g_d;
      st_r_q      <= st_r_d;
      st_g_q      <= st_g_d;
      led_r_q     <= (pwm_cnt_q < cur_r_q);
      led_g_q     <= (pwm_cnt_q < cur_g_q);
      fade_busy_q <= busy_r | busy_g;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign led_r     = led_r_q;
  assign led_g     = led_g_q;
  assign fade_busy = fade_busy_q;

endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader with TICK_DIV=4, PWM_W=8. Stimulus and sampling both
// happen just after the falling clock edge; expected register reads and
// brightness sequences are queued when stimulus is applied and popped as
// the DUT produces them.
module tb_led_fader;

  localparam int TICK_DIV = 4;
  localparam int PWM_W    = 8;

  logic             xclk = 1'b0;
  logic             sys_rst;
  logic             red_in, green_in;
  logic             wr_stb;
  logic [1:0]       wr_addr, rd_addr;
  logic [PWM_W-1:0] wr_data;
  logic [PWM_W-1:0] rd_data;
  logic             led_r, led_g, fade_busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  led_fader #(.TICK_DIV(TICK_DIV), .PWM_W(PWM_W)) dut (
    .xclk(xclk), .sys_rst(sys_rst), .red_in(red_in), .green_in(green_in),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .led_r(led_r), .led_g(led_g), .fade_busy(fade_busy)
  );

  always #5 xclk = ~xclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge xclk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_stb = 1'b1; wr_addr = a; wr_data = d;
    @(negedge xclk);
    wr_stb = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    rd_addr = a;
    @(negedge xclk);
    d = rd_data;
  endtask

  // Wait (bounded) for a channel's brightness to change; ch=0 red, 1 green.
  task automatic next_cur(input bit ch, input int budget, output logic [7:0] v,
                          output int waited, output bit timeout);
    logic [7:0] prev;
    prev    = ch ? dut.cur_g_q : dut.cur_r_q;
    v       = prev;
    waited  = 0;
    timeout = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge xclk);
      v = ch ? dut.cur_g_q : dut.cur_r_q;
      if (v !== prev) begin
        waited  = i;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  // Count high cycles of an LED over n consecutive samples; ch=0 red, 1 green.
  task automatic count_ones(input bit ch, input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge xclk);
      if ((ch ? led_g : led_r) === 1'b1) ones++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d, e;
    int ones;
    sys_rst = 1'b1; red_in = 1'b0; green_in = 1'b0;
    wr_stb = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = 2'd0;
    cycles(3);
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
    checks++; if ({led_r, led_g, fade_busy} !== 3'b000) begin errors++; $display("FAIL reset_outputs: got %b expected 000", {led_r, led_g, fade_busy}); end
    checks++; if (dut.cur_r_q !== 8'h00) begin errors++; $display("FAIL reset_cur_r: got %h expected 00", dut.cur_r_q); end
    sys_rst = 1'b0;
    cycles(4);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      e = exp_q.pop_front();
      checks++; if (d !== e) begin errors++; $display("FAIL reset_reg%0d: got %h expected %h", a, d, e); end
    end
    count_ones(1'b0, 255, ones);
    checks++; if (ones !== 0) begin errors++; $display("FAIL led_r_const0: got %0d high cycles expected 0", ones); end
  endtask

  task automatic test_full_ramp();
    int done_c, bad_c, ones;
    done_c = -1; bad_c = -1;
    red_in = 1'b1;
    for (int c = 1; c <= 1100; c++) begin
      @(negedge xclk);
      if (c >= 2 && fade_busy !== 1'b1 && bad_c < 0) bad_c = c;
      if (dut.cur_r_q === 8'hFF) begin done_c = c; break; end
    end
    checks++; if (done_c < 1017 || done_c > 1020) begin errors++; $display("FAIL full_ramp_cycles: got %0d expected 1017..1020", done_c); end
    checks++; if (bad_c !== -1) begin errors++; $display("FAIL full_ramp_busy: busy low at cycle %0d expected high throughout", bad_c); end
    @(negedge xclk);
    checks++; if (fade_busy !== 1'b1) begin errors++; $display("FAIL busy_tail: got %b expected 1", fade_busy); end
    @(negedge xclk);
    checks++; if (fade_busy !== 1'b0) begin errors++; $display("FAIL busy_end: got %b expected 0", fade_busy); end
    count_ones(1'b0, 255, ones);
    checks++; if (ones !== 255) begin errors++; $display("FAIL led_r_const1: got %0d high cycles expected 255", ones); end
  endtask

  task automatic test_immediate();
    int ones;
    wr(2'd2, 8'h00);
    red_in = 1'b0; green_in = 1'b1;
    @(negedge xclk);
    checks++; if (dut.cur_r_q !== 8'h00) begin errors++; $display("FAIL imm_r_down: got %h expected 00", dut.cur_r_q); end
    checks++; if (dut.cur_g_q !== 8'hFF) begin errors++; $display("FAIL imm_g_up: got %h expected ff", dut.cur_g_q); end
    @(negedge xclk);
    count_ones(1'b1, 255, ones);
    checks++; if (ones !== 255) begin errors++; $display("FAIL led_g_const1: got %0d expected 255", ones); end
    green_in = 1'b0;
    @(negedge xclk);
    checks++; if (dut.cur_g_q !== 8'h00) begin errors++; $display("FAIL imm_g_down: got %h expected 00", dut.cur_g_q); end
    @(negedge xclk);
    count_ones(1'b1, 255, ones);
    checks++; if (ones !== 0) begin errors++; $display("FAIL led_g_const0: got %0d expected 0", ones); end
  endtask

  task automatic test_clamp();
    logic [7:0] v, e;
    int w;
    bit to;
    wr(2'd2, 8'h40);
    wr(2'd0, 8'hA0);
    red_in = 1'b1;
    exp_q.push_back(8'h40); exp_q.push_back(8'h80); exp_q.push_back(8'hA0);
    for (int k = 0; k < 3; k++) begin
      next_cur(1'b0, 8, v, w, to);
      e = exp_q.pop_front();
      checks++; if (to || v !== e) begin errors++; $display("FAIL clamp_seq%0d: got %h expected %h (timeout %0d)", k, v, e, to); end
      if (k > 0) begin
        checks++; if (w !== TICK_DIV) begin errors++; $display("FAIL clamp_spacing%0d: got %0d cycles expected %0d", k, w, TICK_DIV); end
      end
    end
    next_cur(1'b0, 20, v, w, to);
    checks++; if (!to) begin errors++; $display("FAIL clamp_hold: got change to %h expected hold at a0", v); end
  endtask

  task automatic test_regs();
    logic [7:0] d, e, v;
    int w;
    bit to;
    exp_q.push_back(8'h08); exp_q.push_back(8'h08); exp_q.push_back(8'hFF); exp_q.push_back(8'h40);
    rd(2'd3, d); e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL status_before: got %h expected %h", d, e); end
    wr(2'd3, 8'hFF);
    rd(2'd3, d); e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL status_ro: got %h expected %h", d, e); end
    rd(2'd1, d); e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL max_g_rd: got %h expected %h", d, e); end
    rd(2'd2, d); e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL step_rd: got %h expected %h", d, e); end
    wr(2'd0, 8'h33);
    exp_q.push_back(8'h60); exp_q.push_back(8'h33);
    for (int k = 0; k < 2; k++) begin
      next_cur(1'b0, 8, v, w, to);
      e = exp_q.pop_front();
      checks++; if (to || v !== e) begin errors++; $display("FAIL max_lower_seq%0d: got %h expected %h (timeout %0d)", k, v, e, to); end
    end
    rd(2'd0, d);
    checks++; if (d !== 8'h33) begin errors++; $display("FAIL max_r_rd: got %h expected 33", d); end
  endtask

  task automatic test_reverse();
    logic [7:0] v, e;
    int w, ones;
    bit to;
    wr(2'd2, 8'h00);
    red_in = 1'b0;
    cycles(2);
    wr(2'd2, 8'h40);
    wr(2'd0, 8'hFF);
    red_in = 1'b1;
    exp_q.push_back(8'h40); exp_q.push_back(8'h80);
    for (int k = 0; k < 2; k++) begin
      next_cur(1'b0, 8, v, w, to);
      e = exp_q.pop_front();
      checks++; if (to || v !== e) begin errors++; $display("FAIL rev_up%0d: got %h expected %h (timeout %0d)", k, v, e, to); end
    end
    red_in = 1'b0;
    exp_q.push_back(8'h40); exp_q.push_back(8'h00);
    for (int k = 0; k < 2; k++) begin
      next_cur(1'b0, 8, v, w, to);
      e = exp_q.pop_front();
      checks++; if (to || v !== e) begin errors++; $display("FAIL rev_down%0d: got %h expected %h (timeout %0d)", k, v, e, to); end
    end
    wr(2'd0, 8'h80);
    red_in = 1'b1;
    exp_q.push_back(8'h40); exp_q.push_back(8'h80);
    for (int k = 0; k < 2; k++) begin
      next_cur(1'b0, 8, v, w, to);
      e = exp_q.pop_front();
      checks++; if (to || v !== e) begin errors++; $display("FAIL duty_ramp%0d: got %h expected %h (timeout %0d)", k, v, e, to); end
    end
    cycles(3);
    count_ones(1'b0, 255, ones);
    checks++; if (ones !== 128) begin errors++; $display("FAIL duty_128: got %0d high cycles expected 128", ones); end
  endtask

  task automatic test_reset_midramp();
    logic [7:0] d;
    wr(2'd2, 8'h01);
    wr(2'd0, 8'hFF);
    cycles(10);
    rd_addr = 2'd0;
    @(negedge xclk);
    checks++; if (rd_data !== 8'hFF || fade_busy !== 1'b1) begin errors++; $display("FAIL pre_reset: got rd %h busy %b expected ff 1", rd_data, fade_busy); end
    #2 sys_rst = 1'b1;
    #1;
    checks++; if ({led_r, led_g, fade_busy} !== 3'b000 || rd_data !== 8'h00) begin errors++; $display("FAIL midramp_reset_out: got leds/busy %b rd %h expected 000 00", {led_r, led_g, fade_busy}, rd_data); end
    checks++; if (dut.cur_r_q !== 8'h00) begin errors++; $display("FAIL midramp_reset_cur: got %h expected 00", dut.cur_r_q); end
    red_in = 1'b0;
    @(negedge xclk);
    sys_rst = 1'b0;
    cycles(4);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    rd(2'd0, d);
    checks++; if (d !== exp_q[0]) begin errors++; $display("FAIL post_reset_max_r: got %h expected %h", d, exp_q[0]); end
    void'(exp_q.pop_front());
    rd(2'd2, d);
    checks++; if (d !== exp_q[0]) begin errors++; $display("FAIL post_reset_step: got %h expected %h", d, exp_q[0]); end
    void'(exp_q.pop_front());
    rd(2'd3, d);
    checks++; if (d !== exp_q[0]) begin errors++; $display("FAIL post_reset_status: got %h expected %h", d, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_full_ramp();
    test_immediate();
    test_clamp();
    test_regs();
    test_reverse();
    test_reset_midramp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
